mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 256: cycles in WAIT without mem_resp before error is raised.
REQ-002 SHALL have ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_addr  in  32  I-port address.
- i_rmask  in  4  I-port byte read mask; nonzero = request.
- i_rdata  out  32  I-port read data.
- i_resp  out  1  I-port one-cycle completion.
- d_addr  in  32  D-port address.
- d_rmask  in  4  D-port byte read mask.
- d_wmask  in  4  D-port byte write mask.
- d_wdata  in  32  D-port write data.
- d_rdata  out  32  D-port read data.
- d_resp  out  1  D-port one-cycle completion.
- mem_addr  out  32  shared memory address.
- mem_rmask  out  4  shared memory read mask, one-cycle strobe.
- mem_wmask  out  4  shared memory write mask, one-cycle strobe.
- mem_wdata  out  32  shared memory write data.
- mem_rdata  in  32  shared memory read data.
- mem_resp  in  1  shared memory completion.
- error  out  1  sticky protocol/timeout flag.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE and WAIT.
- IDLE: on any upstream request, latch the winner's addr, masks and wdata into mem_* registers, record the owner, and go to ISSUE.
- IDLE with no request: stay in IDLE.
REQ-004 In ISSUE, mem_rmask/mem_wmask SHALL be driven with the latched masks for exactly one cycle, then cleared, with transition to WAIT.
REQ-005 In WAIT, mem masks SHALL be 4'b0.
- On mem_resp: pulse the owner's *_resp in the same cycle, drive the owner's *_rdata = mem_rdata combinationally, and go to IDLE.
REQ-006 The non-owner's resp SHALL stay 0. The non-owner's rdata and the owner's rdata outside its resp cycle SHALL be 'x.
REQ-007 I-port writes SHALL be impossible: mem_wmask SHALL be 0 for every I-owned transaction.
REQ-008 Requesters hold their request stable until resp.
- Minimum latency, request cycle N to resp: N+2 with a 1-cycle memory.
- A request still asserted in the cycle after resp SHALL be treated as new.
REQ-009 A D request with both d_rmask and d_wmask nonzero SHALL set error and be issued as a read only.
REQ-010 mem_resp in IDLE or ISSUE SHALL set error and be ignored.
REQ-011 A wait counter SHALL clear on entry to WAIT.
- When it reaches WAIT_TIMEOUT-1, error SHALL be set and the FSM SHALL remain in WAIT.
REQ-012 error SHALL be sticky until reset.

Reset
REQ-013 While rst=0, asynchronously and independent of clk:
- state=IDLE, owner=I.
- mem_addr=0, mem_rmask=0, mem_wmask=0, mem_wdata=0.
- i_resp=0, d_resp=0, error=0, wait counter=0.
REQ-014 Reset mid-transaction SHALL abandon it silently with no resp; any later mem_resp in IDLE sets error (REQ-010).

Configuration
REQ-015 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the port not served last wins; after reset, D is treated as last-served, so I wins first.
REQ-016 Without MEM_ARB_RR_EN, D SHALL always win simultaneous requests (fixed priority).

Structure
REQ-017 Package mem_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT) and the owner enum (PORT_I/PORT_D).
REQ-018 A combinational sub-module mem_arb_pick SHALL compute the winner from both request bits and the last-served owner; the macro selects its policy.

Verification
REQ-019 Bench SHALL use a 1-cycle memory model and cover:
- Single read: I read 0x0000_0010, rmask=4'hF -> mem_rmask=4'hF one cycle, i_resp two cycles later, i_rdata = memory word; d_resp=0 throughout.
- Conflict: I and D read together -> without MEM_ARB_RR_EN, D is served then I; with it, I, then D, then I on a repeated conflict.
- D write: addr 0x100, wmask=4'b0011, wdata 0xDEADBEEF -> mem_wmask=4'b0011 for one cycle, d_resp; a read-back returns 0xBEEF in the low half.
- Timeout: WAIT_TIMEOUT=8 and memory withholds resp -> error=1 after 8 WAIT cycles; a late resp still completes the owner.
- Illegal D request: rmask=4'hF and wmask=4'hF -> error=1, read issued, mem_wmask=0.
- Reset (rst=0) asserted in WAIT -> all outputs at reset values immediately; a subsequent stray mem_resp sets error.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-port memory arbiter.
//   state_e   - arbiter FSM states (IDLE/ISSUE/WAIT)
//   owner_e   - which upstream port owns the current transaction
//   mem_req_t - request payload latched toward the shared memory
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // The port that did not win last time.
  function automatic owner_e other_port(input owner_e p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between the I and D ports.
// Configuration macro: MEM_ARB_RR_EN
//   defined   - simultaneous requests alternate (the port not served last wins)
//   undefined - D always wins simultaneous requests
// Ports:
//   i_req, d_req  - request present on each port
//   last_served   - owner of the most recent granted transaction
//   valid_c       - some request is present
//   grant_c       - winning port (meaningful only when valid_c)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e last_served,
  output logic   valid_c,
  output owner_e grant_c
);

  assign valid_c = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  // Round-robin only matters on a tie; a lone requester always wins.
  always_comb begin
    grant_c = PORT_I;
    if (i_req && d_req) begin
      grant_c = other_port(last_served);
    end else if (d_req) begin
      grant_c = PORT_D;
    end
  end
`else
  // Fixed priority: history is irrelevant.
  logic unused_last;
  assign unused_last = ^last_served;

  always_comb begin
    grant_c = PORT_I;
    if (d_req) begin
      grant_c = PORT_D;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction (read-only)
// port and a data (read/write) port, one transaction at a time.
// Configuration macro: MEM_ARB_RR_EN selects round-robin arbitration on
// simultaneous requests; without it D has fixed priority.
// Ports:
//   clk, rst                       - clock, async active-low reset
//   i_addr/i_rmask                 - I request (rmask != 0 means request)
//   i_rdata/i_resp                 - I completion (rdata valid only with resp)
//   d_addr/d_rmask/d_wmask/d_wdata - D request
//   d_rdata/d_resp                 - D completion (rdata valid only with resp)
//   mem_addr/mem_rmask/mem_wmask/mem_wdata - registered memory request,
//                                    masks strobe for one cycle
//   mem_rdata/mem_resp             - memory completion
//   error                          - sticky protocol/timeout flag
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_rmask,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_rmask,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        error
);

  localparam int unsigned CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_TIMEOUT - 1);

  state_e           state;
  owner_e           owner;
  owner_e           last_served;
  logic [CNT_W-1:0] wait_cnt;

  logic     i_req_c;
  logic     d_req_c;
  logic     valid_c;
  owner_e   grant_c;
  logic     d_illegal_c;
  mem_req_t sel_c;

  assign i_req_c = (i_rmask != 4'h0);
  assign d_req_c = (d_rmask != 4'h0) || (d_wmask != 4'h0);

  mem_arb_pick u_pick (
    .i_req       (i_req_c),
    .d_req       (d_req_c),
    .last_served (last_served),
    .valid_c     (valid_c),
    .grant_c     (grant_c)
  );

  // D asking to read and write at once is a protocol error.
  assign d_illegal_c = (d_rmask != 4'h0) && (d_wmask != 4'h0);

  // Winner's payload; an I port can never write and an illegal D
  // request degrades to a plain read.
  always_comb begin
    sel_c = '0;
    if (grant_c == PORT_D) begin
      sel_c.addr  = d_addr;
      sel_c.rmask = d_rmask;
      sel_c.wmask = (d_rmask != 4'h0) ? 4'h0 : d_wmask;
      sel_c.wdata = d_wdata;
    end else begin
      sel_c.addr  = i_addr;
      sel_c.rmask = i_rmask;
    end
  end

  // Completion passes straight through from memory in the WAIT cycle it arrives.
  assign i_resp  = (state == WAIT) && mem_resp && (owner == PORT_I);
  assign d_resp  = (state == WAIT) && mem_resp && (owner == PORT_D);
  assign i_rdata = i_resp ? mem_rdata : 'x;
  assign d_rdata = d_resp ? mem_rdata : 'x;

  // Arbiter FSM with registered memory-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= PORT_I;
      last_served <= PORT_D;
      wait_cnt    <= '0;
      mem_addr    <= '0;
      mem_rmask   <= '0;
      mem_wmask   <= '0;
      mem_wdata   <= '0;
      error       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_resp) begin
            error <= 1'b1;
          end
          if (valid_c) begin
            owner       <= grant_c;
            last_served <= grant_c;
            mem_addr    <= sel_c.addr;
            mem_rmask   <= sel_c.rmask;
            mem_wmask   <= sel_c.wmask;
            mem_wdata   <= sel_c.wdata;
            state       <= ISSUE;
            if ((grant_c == PORT_D) && d_illegal_c) begin
              error <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (mem_resp) begin
            error <= 1'b1;
          end
          mem_rmask <= '0;
          mem_wmask <= '0;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (mem_resp) begin
            state <= IDLE;
          end else if (wait_cnt == CNT_MAX) begin
            // Timed out: flag it but keep waiting so a late resp still completes.
            error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a 1-cycle memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr;
  logic [3:0]  i_rmask;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic [31:0] d_addr;
  logic [3:0]  d_rmask;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_resp  = 1'b0;
  logic        error;

  logic        hold_resp   = 1'b0;
  logic        inject_resp = 1'b0;
  logic [31:0] mem [0:255];

  int          strobe_cnt = 0;
  int          i_resp_cnt = 0;
  int          d_resp_cnt = 0;
  logic [3:0]  last_rm    = 4'h0;
  logic [3:0]  last_wm    = 4'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_addr    (i_addr),
    .i_rmask   (i_rmask),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_addr    (d_addr),
    .d_rmask   (d_rmask),
    .d_wmask   (d_wmask),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_addr  (mem_addr),
    .mem_rmask (mem_rmask),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp),
    .error     (error)
  );

  // 1-cycle memory: a strobe seen at an edge answers at the next edge.
  always @(posedge clk) begin
    logic [31:0] word;
    if (mem_rmask != 4'h0 || mem_wmask != 4'h0) begin
      word = mem[mem_addr[9:2]];
      mem_rdata <= word;
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
      end
      mem[mem_addr[9:2]] = word;
    end
    mem_resp <= ((mem_rmask != 4'h0 || mem_wmask != 4'h0) && !hold_resp) || inject_resp;
  end

  // Strobe and response monitor.
  always @(posedge clk) begin
    if (mem_rmask != 4'h0 || mem_wmask != 4'h0) begin
      strobe_cnt <= strobe_cnt + 1;
      last_rm    <= mem_rmask;
      last_wm    <= mem_wmask;
    end
    if (i_resp) i_resp_cnt <= i_resp_cnt + 1;
    if (d_resp) d_resp_cnt <= d_resp_cnt + 1;
  end

  task automatic idle_inputs();
    i_addr = '0; i_rmask = '0;
    d_addr = '0; d_rmask = '0; d_wmask = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Waits up to max_cyc falling edges for any resp; cyc = -1 on timeout.
  task automatic wait_resp(input int max_cyc, output int cyc, output logic gi,
                           output logic gd, output logic [31:0] rd);
    cyc = -1; gi = 1'b0; gd = 1'b0; rd = '0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (i_resp || d_resp) begin
        cyc = k; gi = i_resp; gd = d_resp;
        rd = i_resp ? i_rdata : d_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, 32'h0); end
    n_cmp++; if (mem_rmask !== 4'h0) begin n_bad++; $display("FAIL reset_mem_rmask: got %h want %h", mem_rmask, 4'h0); end
    n_cmp++; if (mem_wmask !== 4'h0) begin n_bad++; $display("FAIL reset_mem_wmask: got %h want %h", mem_wmask, 4'h0); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want %h", mem_wdata, 32'h0); end
    n_cmp++; if ({i_resp, d_resp, error} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {i_resp, d_resp, error}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    int cyc; logic gi, gd; logic [31:0] rd; int s0, d0;
    @(negedge clk);
    s0 = strobe_cnt; d0 = d_resp_cnt;
    i_addr = 32'h0000_0010; i_rmask = 4'hF;
    @(negedge clk);
    n_cmp++; if (mem_rmask !== 4'hF) begin n_bad++; $display("FAIL single_rmask: got %h want %h", mem_rmask, 4'hF); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL single_addr: got %h want %h", mem_addr, 32'h10); end
    n_cmp++; if (mem_wmask !== 4'h0) begin n_bad++; $display("FAIL single_wmask: got %h want %h", mem_wmask, 4'h0); end
    wait_resp(20, cyc, gi, gd, rd);
    i_rmask = 4'h0;
    n_cmp++; if (cyc !== 1 || gi !== 1'b1) begin n_bad++; $display("FAIL single_latency: got cyc=%0d i_resp=%b want cyc=1 i_resp=1", cyc, gi); end
    n_cmp++; if (rd !== 32'hA000_0004) begin n_bad++; $display("FAIL single_rdata: got %h want %h", rd, 32'hA000_0004); end
    n_cmp++; if (mem_rmask !== 4'h0) begin n_bad++; $display("FAIL single_rmask_clear: got %h want %h", mem_rmask, 4'h0); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL single_strobe_len: got %0d want 1", strobe_cnt - s0); end
    n_cmp++; if (d_resp_cnt !== d0) begin n_bad++; $display("FAIL single_no_dresp: got %0d want %0d", d_resp_cnt, d0); end
  endtask

  task automatic test_conflict();
    int cyc; logic gi, gd; logic [31:0] rd;
    logic w1_d, w3_d;
`ifdef MEM_ARB_RR_EN
    w1_d = 1'b0; w3_d = 1'b0;
`else
    w1_d = 1'b1; w3_d = 1'b1;
`endif
    do_reset();
    @(negedge clk);
    i_addr = 32'h20; i_rmask = 4'hF;
    d_addr = 32'h30; d_rmask = 4'hF;
    wait_resp(20, cyc, gi, gd, rd);
    if (w1_d) d_rmask = 4'h0; else i_rmask = 4'h0;
    n_cmp++; if (cyc !== 2 || gd !== w1_d || gi !== !w1_d) begin n_bad++; $display("FAIL conflict_first: got cyc=%0d i=%b d=%b want cyc=2 d=%b", cyc, gi, gd, w1_d); end
    n_cmp++; if (rd !== (w1_d ? 32'hA000_000C : 32'hA000_0008)) begin n_bad++; $display("FAIL conflict_first_rdata: got %h", rd); end
    wait_resp(20, cyc, gi, gd, rd);
    idle_inputs();
    n_cmp++; if (cyc !== 3 || gd !== !w1_d || gi !== w1_d) begin n_bad++; $display("FAIL conflict_second: got cyc=%0d i=%b d=%b want cyc=3 d=%b", cyc, gi, gd, !w1_d); end
    n_cmp++; if (rd !== (w1_d ? 32'hA000_0008 : 32'hA000_000C)) begin n_bad++; $display("FAIL conflict_second_rdata: got %h", rd); end
    @(negedge clk);
    i_addr = 32'h20; i_rmask = 4'hF;
    d_addr = 32'h30; d_rmask = 4'hF;
    wait_resp(20, cyc, gi, gd, rd);
    idle_inputs();
    n_cmp++; if (cyc !== 2 || gd !== w3_d || gi !== !w3_d) begin n_bad++; $display("FAIL conflict_repeat: got cyc=%0d i=%b d=%b want cyc=2 d=%b", cyc, gi, gd, w3_d); end
    @(negedge clk);
  endtask

  task automatic test_d_write();
    int cyc; logic gi, gd; logic [31:0] rd; int s0;
    @(negedge clk);
    s0 = strobe_cnt;
    d_addr = 32'h100; d_wmask = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    wait_resp(20, cyc, gi, gd, rd);
    idle_inputs();
    n_cmp++; if (cyc !== 2 || gd !== 1'b1) begin n_bad++; $display("FAIL write_resp: got cyc=%0d d_resp=%b want cyc=2 d_resp=1", cyc, gd); end
    @(negedge clk);
    n_cmp++; if (last_wm !== 4'b0011 || last_rm !== 4'h0) begin n_bad++; $display("FAIL write_masks: got w=%b r=%b want w=0011 r=0000", last_wm, last_rm); end
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL write_strobe_len: got %0d want 1", strobe_cnt - s0); end
    d_addr = 32'h100; d_rmask = 4'hF;
    wait_resp(20, cyc, gi, gd, rd);
    idle_inputs();
    n_cmp++; if (gd !== 1'b1 || rd !== 32'hA000_BEEF) begin n_bad++; $display("FAIL write_readback: got d_resp=%b %h want 1 %h", gd, rd, 32'hA000_BEEF); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL write_no_error: got %b want 0", error); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc; logic gi, gd; logic [31:0] rd; int s0;
    do_reset();
    @(negedge clk);
    s0 = strobe_cnt;
    i_addr = 32'h10; i_rmask = 4'hF;
    wait_resp(20, cyc, gi, gd, rd);
    n_cmp++; if (cyc !== 2 || gi !== 1'b1) begin n_bad++; $display("FAIL b2b_first: got cyc=%0d i_resp=%b want 2 1", cyc, gi); end
    wait_resp(20, cyc, gi, gd, rd);
    idle_inputs();
    n_cmp++; if (cyc !== 3 || gi !== 1'b1) begin n_bad++; $display("FAIL b2b_second: got cyc=%0d i_resp=%b want 3 1", cyc, gi); end
    @(negedge clk);
    n_cmp++; if (strobe_cnt - s0 !== 2) begin n_bad++; $display("FAIL b2b_strobes: got %0d want 2", strobe_cnt - s0); end
  endtask

  task automatic test_timeout();
    int cyc; logic gi, gd; logic [31:0] rd; int r0;
    do_reset();
    hold_resp = 1'b1;
    @(negedge clk);
    r0 = i_resp_cnt;
    i_addr = 32'h40; i_rmask = 4'hF;
    for (int k = 1; k <= 9; k++) @(negedge clk);
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got error=%b want 0", error); end
    @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL timeout_flag: got error=%b want 1", error); end
    n_cmp++; if (i_resp_cnt !== r0 || i_resp !== 1'b0) begin n_bad++; $display("FAIL timeout_no_resp: got %0d resps want 0", i_resp_cnt - r0); end
    inject_resp = 1'b1;
    wait_resp(5, cyc, gi, gd, rd);
    inject_resp = 1'b0;
    idle_inputs();
    hold_resp = 1'b0;
    n_cmp++; if (cyc !== 1 || gi !== 1'b1 || rd !== 32'hA000_0010) begin n_bad++; $display("FAIL timeout_late_resp: got cyc=%0d i=%b %h want 1 1 %h", cyc, gi, rd, 32'hA000_0010); end
    @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got error=%b want 1", error); end
  endtask

  task automatic test_illegal_d();
    int cyc; logic gi, gd; logic [31:0] rd; int s0;
    do_reset();
    @(negedge clk);
    s0 = strobe_cnt;
    d_addr = 32'h50; d_rmask = 4'hF; d_wmask = 4'hF; d_wdata = 32'h1234_5678;
    wait_resp(20, cyc, gi, gd, rd);
    idle_inputs();
    n_cmp++; if (cyc !== 2 || gd !== 1'b1 || rd !== 32'hA000_0014) begin n_bad++; $display("FAIL illegal_read: got cyc=%0d d=%b %h want 2 1 %h", cyc, gd, rd, 32'hA000_0014); end
    @(negedge clk);
    n_cmp++; if (last_rm !== 4'hF || last_wm !== 4'h0) begin n_bad++; $display("FAIL illegal_masks: got r=%h w=%h want r=f w=0", last_rm, last_wm); end
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL illegal_strobes: got %0d want 1", strobe_cnt - s0); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL illegal_error: got %b want 1", error); end
  endtask

  task automatic test_reset_in_wait();
    int r0;
    do_reset();
    hold_resp = 1'b1;
    @(negedge clk);
    i_addr = 32'h60; i_rmask = 4'hF;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (mem_addr !== 32'h0 || mem_rmask !== 4'h0 || mem_wmask !== 4'h0) begin n_bad++; $display("FAIL rstwait_mem: got addr=%h r=%h w=%h want 0", mem_addr, mem_rmask, mem_wmask); end
    n_cmp++; if ({i_resp, d_resp, error} !== 3'b000) begin n_bad++; $display("FAIL rstwait_flags: got %b want 000", {i_resp, d_resp, error}); end
    idle_inputs();
    hold_resp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    r0 = i_resp_cnt;
    inject_resp = 1'b1;
    @(negedge clk);
    inject_resp = 1'b0;
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rstwait_pre_stray: got error=%b want 0", error); end
    @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL rstwait_stray_error: got error=%b want 1", error); end
    @(negedge clk);
    n_cmp++; if (error !== 1'b1 || i_resp_cnt !== r0) begin n_bad++; $display("FAIL rstwait_sticky: got error=%b resps=%0d want 1 0", error, i_resp_cnt - r0); end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    test_reset();
    test_single_read();
    test_conflict();
    test_d_write();
    test_back_to_back();
    test_timeout();
    test_illegal_d();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
